// File: rtl/yasac_io_bank.sv
// yasac_io_bank: output port registers with strobes, synchronised input ports, registered read path.
// Define YASAC_IO_CHGIRQ_EN to add per-input change flags, an IRQ mask and the IRQ output.
module yasac_io_bank #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8,
    parameter int N_IN   = 8,
    parameter int ADDR_W = 5
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [ADDR_W-1:0]        ADDR,
    input  logic [DATA_W-1:0]        WDATA,
    input  logic                     WE,
    input  logic                     RE,
    output logic [DATA_W-1:0]        RDATA,
    output logic                     RVALID,
    output logic [N_OUT*DATA_W-1:0]  PORT_OUT,
    output logic [N_OUT-1:0]         PORT_OUT_STB,
    input  logic [N_IN*DATA_W-1:0]   PORT_IN,
    output logic                     IRQ
);

    localparam int OW = N_OUT * DATA_W;
    localparam int IW = N_IN * DATA_W;
    localparam logic [ADDR_W-1:0] CHG_A  = ADDR_W'(N_OUT + N_IN);
    localparam logic [ADDR_W-1:0] MASK_A = ADDR_W'(N_OUT + N_IN + 1);

    logic [OW-1:0]     out_q;
    logic [N_OUT-1:0]  stb_q;
    logic [N_OUT-1:0]  wr_sel;
    logic [IW-1:0]     s1;
    logic [IW-1:0]     s2;
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < N_OUT; i++) begin
            wr_sel[i] = WE && (ADDR == ADDR_W'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_q <= '0;
            stb_q <= '0;
        end else begin
            stb_q <= wr_sel;
            for (int i = 0; i < N_OUT; i++) begin
                if (wr_sel[i]) begin
                    out_q[i*DATA_W +: DATA_W] <= WDATA;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= PORT_IN;
            s2 <= s1;
        end
    end

`ifdef YASAC_IO_CHGIRQ_EN
    logic [IW-1:0]   p;
    logic [N_IN-1:0] chg;
    logic [N_IN-1:0] mask;
    logic [N_IN-1:0] chg_set;
    logic [N_IN-1:0] chg_clr;

    always_comb begin
        chg_set = '0;
        chg_clr = '0;
        for (int j = 0; j < N_IN; j++) begin
            chg_set[j] = s2[j*DATA_W +: DATA_W] != p[j*DATA_W +: DATA_W];
        end
        if (WE && (ADDR == CHG_A)) begin
            chg_clr = WDATA[N_IN-1:0];
        end
    end

    // set is OR'd after the clear so a same-edge event keeps the flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            p    <= '0;
            chg  <= '0;
            mask <= '0;
        end else begin
            p   <= s2;
            chg <= (chg & ~chg_clr) | chg_set;
            if (WE && (ADDR == MASK_A)) begin
                mask <= WDATA[N_IN-1:0];
            end
        end
    end

    assign IRQ = |(chg & mask);
`else
    assign IRQ = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (ADDR == ADDR_W'(i)) begin
                rd_mux = out_q[i*DATA_W +: DATA_W];
            end
        end
        for (int j = 0; j < N_IN; j++) begin
            if (ADDR == ADDR_W'(N_OUT + j)) begin
                rd_mux = s2[j*DATA_W +: DATA_W];
            end
        end
`ifdef YASAC_IO_CHGIRQ_EN
        if (ADDR == CHG_A) begin
            rd_mux[N_IN-1:0] = chg;
        end
        if (ADDR == MASK_A) begin
            rd_mux[N_IN-1:0] = mask;
        end
`endif
    end

    // rd_mux sees register values before this edge's write: read-before-write
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= RE;
            if (RE) begin
                rdata_q <= rd_mux;
            end
        end
    end

    assign RDATA        = rdata_q;
    assign RVALID       = rvalid_q;
    assign PORT_OUT     = out_q;
    assign PORT_OUT_STB = stb_q;

endmodule

// File: tb/tb_yasac_io_bank.sv
// tb_yasac_io_bank: directed scoreboard bench for yasac_io_bank (default parameters).
// Build with +define+YASAC_IO_CHGIRQ_EN to exercise change flags and IRQ.
module tb_yasac_io_bank;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [4:0]  ADDR;
    logic [7:0]  WDATA;
    logic        WE;
    logic        RE;
    logic [7:0]  RDATA;
    logic        RVALID;
    logic [63:0] PORT_OUT;
    logic [7:0]  PORT_OUT_STB;
    logic [63:0] PORT_IN;
    logic        IRQ;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    logic [63:0] exp_po;

    always #5 CLK = ~CLK;

    yasac_io_bank dut (
        .CLK(CLK),
        .RESET(RESET),
        .ADDR(ADDR),
        .WDATA(WDATA),
        .WE(WE),
        .RE(RE),
        .RDATA(RDATA),
        .RVALID(RVALID),
        .PORT_OUT(PORT_OUT),
        .PORT_OUT_STB(PORT_OUT_STB),
        .PORT_IN(PORT_IN),
        .IRQ(IRQ)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock edge; outputs are sampled 1ns later and the read scoreboard drained
    task automatic step();
        @(posedge CLK);
        #1;
        chk("rvalid", RVALID, exp_q.size() != 0);
        if (RVALID && exp_q.size() != 0) begin
            chk("rdata", RDATA, exp_q.pop_front());
        end
        exp_q.delete();
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        ADDR  = a;
        WDATA = d;
        WE    = 1'b1;
        step();
        WE = 1'b0;
        if (a < 8) exp_po[a*8 +: 8] = d;
        chk("port_out", PORT_OUT, exp_po);
        chk("stb", PORT_OUT_STB, (a < 8) ? (64'd1 << a) : 64'd0);
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] e);
        ADDR = a;
        RE   = 1'b1;
        exp_q.push_back(e);
        step();
        RE = 1'b0;
    endtask

    initial begin
        RESET   = 1'b1;
        WE      = 1'b0;
        RE      = 1'b0;
        ADDR    = '0;
        WDATA   = '0;
        PORT_IN = '0;
        exp_po  = '0;
        step();
        step();
        RESET = 1'b0;
        chk("rst_port_out", PORT_OUT, 64'd0);
        chk("rst_stb", PORT_OUT_STB, 64'd0);
        chk("rst_rdata", RDATA, 64'd0);
        chk("rst_irq", IRQ, 64'd0);

        // scenario 1: write then read back, strobe lasts one cycle
        wr(5'd3, 8'hA5);
        chk("po_31_24", PORT_OUT[31:24], 64'hA5);
        step();
        chk("stb_one_cycle", PORT_OUT_STB, 64'd0);
        rd(5'd3, 8'hA5);
        step();
        chk("rdata_hold", RDATA, 64'hA5);

        // scenario 2: first edge captures into s1, reads on the next three edges
        PORT_IN[23:16] = 8'h3C;
        step();
        rd(5'd10, 8'h00);
        rd(5'd10, 8'h3C);
        rd(5'd10, 8'h3C);

        // scenario 3: simultaneous write and read returns the old value
        wr(5'd5, 8'h11);
        ADDR  = 5'd5;
        WDATA = 8'h22;
        WE    = 1'b1;
        RE    = 1'b1;
        exp_q.push_back(8'h11);
        step();
        WE = 1'b0;
        RE = 1'b0;
        exp_po[47:40] = 8'h22;
        chk("rbw_port_out", PORT_OUT, exp_po);
        chk("rbw_stb", PORT_OUT_STB, 64'h20);
        rd(5'd5, 8'h22);

        // scenario 4: unmapped read, write to an input port address
        rd(5'd30, 8'h00);
        wr(5'd9, 8'h77);
        wr(5'd31, 8'h5A);

`ifdef YASAC_IO_CHGIRQ_EN
        // scenario 5: change flags and masked IRQ
        wr(5'd17, 8'h04);
        wr(5'd16, 8'hFF);
        chk("irq_cleared", IRQ, 64'd0);
        rd(5'd16, 8'h00);
        PORT_IN[23:16] = 8'hC3;
        step();
        step();
        chk("irq_edge2", IRQ, 64'd0);
        step();
        chk("irq_edge3", IRQ, 64'd1);
        rd(5'd16, 8'h04);
        wr(5'd16, 8'h04);
        chk("irq_w1c", IRQ, 64'd0);
        rd(5'd16, 8'h00);
        PORT_IN[15:8] = 8'h5A;
        step();
        step();
        step();
        rd(5'd16, 8'h02);
        chk("irq_masked", IRQ, 64'd0);
        rd(5'd17, 8'h04);
`else
        // without the feature, flag and mask addresses are unmapped
        wr(5'd17, 8'hFF);
        rd(5'd16, 8'h00);
        rd(5'd17, 8'h00);
        chk("irq_tied", IRQ, 64'd0);
`endif

        // scenario 6: reset in the middle of a read stream discards the pending read
        ADDR = 5'd3;
        RE   = 1'b1;
        exp_q.push_back(8'hA5);
        step();
        exp_q.push_back(8'hA5);
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        RE    = 1'b0;
        exp_po = '0;
        chk("rst2_port_out", PORT_OUT, exp_po);
        chk("rst2_stb", PORT_OUT_STB, 64'd0);
        chk("rst2_irq", IRQ, 64'd0);
        chk("rst2_rdata", RDATA, 64'd0);
        step();

        wr(5'd3, 8'hA5);
        chk("po2_31_24", PORT_OUT[31:24], 64'hA5);
        step();
        chk("stb2_one_cycle", PORT_OUT_STB, 64'd0);
        rd(5'd3, 8'hA5);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
